// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit pipeline memory stage.
//   DATA_W / FLAG_W / RW_W : data, flag and write-back-control widths
//   DEPTH                  : data-RAM entries (2**DATA_W, full address coverage)
//   MMIO_ADDR              : address claimed by io_out when MEM_MMIO_EN is defined
//   RW_EN_BIT              : register-write enable bit inside RW_ex / RW_dm
//   state_t                : clear sequencer / run state
package proc_pkg;
    localparam int DATA_W    = 8;
    localparam int FLAG_W    = 4;
    localparam int RW_W      = 5;
    localparam int DEPTH     = 256;
    localparam int RW_EN_BIT = 4;

    localparam logic [DATA_W-1:0] MMIO_ADDR = 8'hFF;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/data_mem.sv
// Single-port synchronous RAM, DEPTH x DW.
//   clk   : rising-edge clock
//   we    : write enable (write wins; no read in a write cycle)
//   re    : read enable, rdata is registered
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, holds between reads
module data_mem
    import proc_pkg::*;
#(
    parameter int AW = DATA_W,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end
endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: performs the load/store chosen by the execute stage
// on a 256x8 data RAM and registers write-back data, flags and destination.
// After every reset the RAM is zero-cleared (INIT) while stall_dm holds
// upstream; the stage then runs (RUN) with one cycle of latency.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   ans_ex          : ALU result / memory address
//   B_Bypass        : store data
//   flag_ex, RW_ex  : flags and write-back control, registered through
//   mem_en_ex       : access request; mem_rw_ex 1=store 0=load
//   mem_mux_sel_ex  : take write-back data from memory (loads only)
//   ans_dm, flag_dm, RW_dm : write-back outputs (zero bubble during INIT)
//   stall_dm        : high while the RAM clear is running
//   io_out          : memory-mapped output register
//
// Build option: MEM_MMIO_EN maps address 0xFF to io_out instead of RAM.
module memory_stage
    import proc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] B_Bypass,
    input  logic [FLAG_W-1:0] flag_ex,
    input  logic              mem_en_ex,
    input  logic              mem_rw_ex,
    input  logic              mem_mux_sel_ex,
    input  logic [RW_W-1:0]   RW_ex,
    output logic [DATA_W-1:0] ans_dm,
    output logic [FLAG_W-1:0] flag_dm,
    output logic [RW_W-1:0]   RW_dm,
    output logic              stall_dm,
    output logic [DATA_W-1:0] io_out
);
    localparam logic [DATA_W-1:0] LAST_ADDR = DATA_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] cnt;

    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_addr, ram_wdata, ram_rdata;

    logic              is_store, is_load, mmio_hit;
    logic [DATA_W-1:0] ans_q;
    logic              rd_sel_q;

    assign is_store = mem_en_ex & mem_rw_ex;
    assign is_load  = mem_en_ex & ~mem_rw_ex;

`ifdef MEM_MMIO_EN
    assign mmio_hit = (ans_ex == MMIO_ADDR);
`else
    assign mmio_hit = 1'b0;
`endif

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == LAST_ADDR)
            state_nxt = RUN;
    end

    // ---- FSM: outputs (stall and RAM port mux) ----
    always_comb begin
        stall_dm  = (state == INIT);
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = ans_ex;
        ram_wdata = B_Bypass;
        // Nothing touches the RAM in a reset cycle, including the clear.
        if (!reset) begin
            if (state == INIT) begin
                ram_we    = 1'b1;
                ram_addr  = cnt;
                ram_wdata = '0;
            end else begin
                ram_we = is_store & ~mmio_hit;
                // Only loads whose data is actually selected need a read.
                ram_re = is_load & mem_mux_sel_ex & ~mmio_hit;
            end
        end
    end

    // Clear counter: runs only in INIT, wraps back to 0 on entering RUN.
    always_ff @(posedge clk) begin
        if (reset || state != INIT) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
    end

    data_mem #(.AW(DATA_W), .DW(DATA_W)) u_data_mem (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

`ifdef MEM_MMIO_EN
    // io_out is only cleared by reset; the INIT sweep leaves it alone.
    always_ff @(posedge clk) begin
        if (reset)
            io_out <= '0;
        else if (state == RUN && is_store && mmio_hit)
            io_out <= B_Bypass;
    end
`else
    assign io_out = '0;
`endif

    // Write-back registers. An MMIO load folds io_out into the ALU path so
    // the RAM read register is only consulted for real RAM loads.
    always_ff @(posedge clk) begin
        if (reset || state == INIT) begin
            ans_q    <= '0;
            flag_dm  <= '0;
            RW_dm    <= '0;
            rd_sel_q <= 1'b0;
        end else begin
            ans_q    <= (is_load & mem_mux_sel_ex & mmio_hit) ? io_out : ans_ex;
            flag_dm  <= flag_ex;
            RW_dm    <= RW_ex;
            rd_sel_q <= ram_re;
        end
    end

    // RAM read data is already registered, so select it after the edge.
    assign ans_dm = rd_sel_q ? ram_rdata : ans_q;
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ans_ex = '0, B_Bypass = '0;
    logic [3:0] flag_ex = '0;
    logic       mem_en_ex = 1'b0, mem_rw_ex = 1'b0, mem_mux_sel_ex = 1'b0;
    logic [4:0] RW_ex = '0;
    logic [7:0] ans_dm, io_out;
    logic [3:0] flag_dm;
    logic [4:0] RW_dm;
    logic       stall_dm;

`ifdef MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    memory_stage dut (
        .clk(clk), .reset(reset), .ans_ex(ans_ex), .B_Bypass(B_Bypass),
        .flag_ex(flag_ex), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
        .mem_mux_sel_ex(mem_mux_sel_ex), .RW_ex(RW_ex), .ans_dm(ans_dm),
        .flag_dm(flag_dm), .RW_dm(RW_dm), .stall_dm(stall_dm), .io_out(io_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: memory contents and io register as the spec describes them.
    logic [7:0] mem_m [256];
    logic [7:0] io_m;
    logic [7:0] exp_ans;
    logic [3:0] exp_flag;
    logic [4:0] exp_rw;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    endtask

    // Present one ex-stage operation for one edge; compute expected outputs
    // from the model before applying the store to it.
    task automatic drive(input logic en, input logic rw, input logic sel,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic [3:0] f, input logic [4:0] r);
        mem_en_ex = en; mem_rw_ex = rw; mem_mux_sel_ex = sel;
        ans_ex = a; B_Bypass = d; flag_ex = f; RW_ex = r;
        if (en && !rw && sel)
            exp_ans = (MMIO && a == 8'hFF) ? io_m : mem_m[a];
        else
            exp_ans = a;
        exp_flag = f;
        exp_rw   = r;
        if (en && rw) begin
            if (MMIO && a == 8'hFF) io_m = d;
            else                    mem_m[a] = d;
        end
        @(posedge clk); #1;
    endtask

    // Count cycles of stall after reset release; outputs must stay zero.
    task automatic wait_init(input string tag);
        int n = 0;
        int nz = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!stall_dm) break;
            n++;
            if (ans_dm !== 8'h00 || flag_dm !== 4'h0 || RW_dm !== 5'h00) nz++;
        end
        checks++;
        if (n !== 256) begin
            errors++;
            $display("FAIL %s stall_len: got %0d expected 256", tag, n);
        end
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL %s init_bubble: %0d cycles with nonzero outputs, expected 0", tag, nz);
        end
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ans_dm !== 8'h00 || flag_dm !== 4'h0 || RW_dm !== 5'h00 || io_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got ans=%h flag=%h rw=%h io=%h expected all 0",
                     ans_dm, flag_dm, RW_dm, io_out);
        end
        checks++;
        if (stall_dm !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: got %b expected 1", stall_dm);
        end
        io_m = 8'h00;
        reset = 1'b0;
        wait_init("reset");
    endtask

    task automatic test_store_load();
        drive(1, 1, 0, 8'h40, 8'hC0, 4'h0, 5'h00);
        drive(1, 0, 1, 8'h40, 8'h00, 4'h3, 5'b10101);
        checks++;
        if (ans_dm !== 8'hC0) begin
            errors++;
            $display("FAIL store_load_ans: got %h expected c0", ans_dm);
        end
        checks++;
        if (RW_dm !== 5'b10101) begin
            errors++;
            $display("FAIL store_load_rw: got %b expected 10101", RW_dm);
        end
    endtask

    task automatic test_passthrough();
        drive(0, 0, 1, 8'h80, 8'h5A, 4'b1010, 5'b10011);
        checks++;
        if (ans_dm !== 8'h80 || flag_dm !== 4'b1010 || RW_dm !== 5'b10011) begin
            errors++;
            $display("FAIL passthrough: got ans=%h flag=%b rw=%b expected 80 1010 10011",
                     ans_dm, flag_dm, RW_dm);
        end
    endtask

    task automatic test_cleared();
        drive(1, 0, 1, 8'h7F, 8'hAA, 4'h0, 5'h00);
        checks++;
        if (ans_dm !== 8'h00) begin
            errors++;
            $display("FAIL cleared_load: got %h expected 00", ans_dm);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a, d;
            a = 8'($urandom);
            d = 8'($urandom);
            drive(1, 1, 1, a, d, 4'($urandom), 5'($urandom));
            drive(1, 0, 1, a, 8'($urandom), 4'($urandom), 5'($urandom));
            checks++;
            if (ans_dm !== d) begin
                errors++;
                $display("FAIL b2b_raw[%0d] addr=%h: got %h expected %h", i, a, ans_dm, d);
            end
        end
    endtask

    task automatic test_mmio();
        logic [7:0] exp_io;
        exp_io = MMIO ? 8'h3C : 8'h00;
        drive(1, 1, 0, 8'hFF, 8'h3C, 4'h0, 5'h00);
        checks++;
        if (io_out !== exp_io) begin
            errors++;
            $display("FAIL mmio_io_out: got %h expected %h", io_out, exp_io);
        end
        drive(1, 0, 1, 8'hFF, 8'h00, 4'h0, 5'h00);
        checks++;
        if (ans_dm !== 8'h3C) begin
            errors++;
            $display("FAIL mmio_load: got %h expected 3c", ans_dm);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 31));
            drive(1'($urandom), 1'($urandom), 1'($urandom), a, 8'($urandom),
                  4'($urandom), 5'($urandom));
            checks++;
            if (ans_dm !== exp_ans || flag_dm !== exp_flag || RW_dm !== exp_rw ||
                io_out !== io_m || stall_dm !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d]: got ans=%h flag=%h rw=%h io=%h stall=%b expected %h %h %h %h 0",
                         i, ans_dm, flag_dm, RW_dm, io_out, stall_dm,
                         exp_ans, exp_flag, exp_rw, io_m);
            end
        end
    endtask

    task automatic test_midrun_reset();
        drive(1, 1, 0, 8'h10, 8'h55, 4'hF, 5'h1F);
        // A store presented together with reset must not happen.
        mem_en_ex = 1'b1; mem_rw_ex = 1'b1; ans_ex = 8'h20; B_Bypass = 8'h99;
        flag_ex = 4'hF; RW_ex = 5'h1F;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ans_dm !== 8'h00 || flag_dm !== 4'h0 || RW_dm !== 5'h00 || stall_dm !== 1'b1) begin
            errors++;
            $display("FAIL midrun_squash: got ans=%h flag=%h rw=%h stall=%b expected 0 0 0 1",
                     ans_dm, flag_dm, RW_dm, stall_dm);
        end
        io_m = 8'h00;
        reset = 1'b0;
        wait_init("midrun");
        drive(1, 0, 1, 8'h10, 8'h00, 4'h0, 5'h00);
        checks++;
        if (ans_dm !== 8'h00) begin
            errors++;
            $display("FAIL midrun_cleared_10: got %h expected 00", ans_dm);
        end
        drive(1, 0, 1, 8'h20, 8'h00, 4'h0, 5'h00);
        checks++;
        if (ans_dm !== 8'h00) begin
            errors++;
            $display("FAIL midrun_no_store_20: got %h expected 00", ans_dm);
        end
        checks++;
        if (io_out !== 8'h00) begin
            errors++;
            $display("FAIL midrun_io: got %h expected 00", io_out);
        end
    endtask

    initial begin
        model_clear();
        io_m = 8'h00;
        test_reset();
        test_store_load();
        test_passthrough();
        test_cleared();
        test_back_to_back();
        test_mmio();
        test_random();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
